// File: rtl/span_scheduler.sv
// span_scheduler: per-scanline sequencer that time-shares one square-interval evaluator across
// NSHAPE slots and streams non-empty [s,t] spans. Optional macro SPAN_CLIP_EN clips spans to H_RES.
module span_scheduler #(
    parameter int CORDW  = 10,
    parameter int NSHAPE = 8,
    parameter int COLRW  = 4,
    parameter int H_RES  = 640,
    localparam int IDXW  = $clog2(NSHAPE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic             cfg_en,
    input  logic [CORDW-1:0] cfg_x0,
    input  logic [CORDW-1:0] cfg_y0,
    input  logic [CORDW-1:0] cfg_size,
    input  logic [COLRW-1:0] cfg_color,
    input  logic             line_start,
    input  logic [CORDW-1:0] line_y,
    output logic             busy,
    output logic             line_done,
    output logic             span_valid,
    input  logic             span_ready,
    output logic [CORDW-1:0] span_s,
    output logic [CORDW-1:0] span_t,
    output logic [COLRW-1:0] span_color,
    output logic [IDXW-1:0]  span_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSHAPE - 1);

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic [CORDW-1:0] r_y;
    logic             r_busy;
    logic             r_line_done;
    logic             r_span_valid;
    logic [CORDW-1:0] r_span_s;
    logic [CORDW-1:0] r_span_t;
    logic [COLRW-1:0] r_span_color;
    logic [IDXW-1:0]  r_span_idx;

    logic             r_en    [NSHAPE];
    logic [CORDW-1:0] r_x0    [NSHAPE];
    logic [CORDW-1:0] r_y0    [NSHAPE];
    logic [CORDW-1:0] r_size  [NSHAPE];
    logic [COLRW-1:0] r_color [NSHAPE];

    logic             w_cfg_wr;
    logic [CORDW-1:0] w_x0;
    logic [CORDW-1:0] w_y0;
    logic [CORDW-1:0] w_size;
    logic [CORDW-1:0] w_x1;
    logic [CORDW-1:0] w_y1;
    logic [CORDW-1:0] w_s;
    logic [CORDW-1:0] w_t;
    logic [CORDW-1:0] w_t_out;
    logic             w_raw_hit;
    logic             w_hit;

    assign w_cfg_wr = cfg_we && (r_state == S_IDLE);

    // Slot table: writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSHAPE; i++) begin
                r_en[i]    <= 1'b0;
                r_x0[i]    <= '0;
                r_y0[i]    <= '0;
                r_size[i]  <= '0;
                r_color[i] <= '0;
            end
        end else if (w_cfg_wr) begin
            r_en[cfg_idx]    <= cfg_en;
            r_x0[cfg_idx]    <= cfg_x0;
            r_y0[cfg_idx]    <= cfg_y0;
            r_size[cfg_idx]  <= cfg_size;
            r_color[cfg_idx] <= cfg_color;
        end
    end

    // Square-interval evaluator; ends wrap mod 2^CORDW, an outside line yields the empty span s=1,t=0
    always_comb begin
        w_x0   = r_x0[r_idx];
        w_y0   = r_y0[r_idx];
        w_size = r_size[r_idx];
        w_x1   = w_x0 + w_size;
        w_y1   = w_y0 + w_size;
        if ((r_y >= w_y0) && (r_y <= w_y1)) begin
            w_s = w_x0;
            w_t = w_x1;
        end else begin
            w_s = CORDW'(1);
            w_t = '0;
        end
        w_raw_hit = r_en[r_idx] && (w_s <= w_t);
    end

    // Visible-width clipping of the evaluated span
    always_comb begin
        w_hit   = 1'b0;
        w_t_out = w_t;
`ifdef SPAN_CLIP_EN
        if (w_raw_hit && (int'(w_s) < H_RES)) begin
            w_hit = 1'b1;
        end else begin
            w_hit = 1'b0;
        end
        if (int'(w_t) > (H_RES - 1)) begin
            w_t_out = CORDW'(H_RES - 1);
        end else begin
            w_t_out = w_t;
        end
`else
        w_hit   = w_raw_hit;
        w_t_out = w_t;
`endif
    end

    // Line sequencer with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_y          <= '0;
            r_busy       <= 1'b0;
            r_line_done  <= 1'b0;
            r_span_valid <= 1'b0;
            r_span_s     <= '0;
            r_span_t     <= '0;
            r_span_color <= '0;
            r_span_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_line_done <= 1'b0;
                    if (line_start) begin
                        r_y     <= line_y;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_hit) begin
                        r_span_s     <= w_s;
                        r_span_t     <= w_t_out;
                        r_span_color <= r_color[r_idx];
                        r_span_idx   <= r_idx;
                        r_span_valid <= 1'b1;
                        r_state      <= S_EMIT;
                    end else if (r_idx == LAST_IDX) begin
                        r_line_done <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                S_EMIT: begin
                    if (span_ready) begin
                        r_span_valid <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_line_done <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + IDXW'(1);
                            r_state <= S_EVAL;
                        end
                    end
                end
                S_DONE: begin
                    r_line_done <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_line_done  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_span_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign line_done  = r_line_done;
    assign span_valid = r_span_valid;
    assign span_s     = r_span_s;
    assign span_t     = r_span_t;
    assign span_color = r_span_color;
    assign span_idx   = r_span_idx;

endmodule
